// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage controller:
// RV32 load/store funct3 codes, FSM state encoding and dmem command encoders.
package ma_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ma_state_e;

    // dmem read command: valid bit followed by the full funct3 (carries signedness)
    function automatic logic [3:0] enc_mem_read(input logic [2:0] funct3);
        return {1'b1, funct3};
    endfunction

    // dmem write command: valid bit followed by the access size
    function automatic logic [2:0] enc_mem_write(input logic [2:0] funct3);
        return {1'b1, funct3[1:0]};
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if (funct3[1:0] == F3_LH[1:0])
            r = addr_lo[0];
        else if (funct3[1:0] == F3_LW[1:0])
            r = (addr_lo != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/ma_watchdog.sv
// Watchdog for the memory-access stage: counts enabled cycles and flags
// expiry on the TIMEOUT_CYCLES-th consecutive enabled cycle.
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module ma_watchdog
    import ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [CNT_W-1:0] r_count;

            // Count enabled cycles; clear restarts the window
            always_ff @(posedge clock) begin
                if (reset || clear)
                    r_count <= '0;
                else if (enable)
                    r_count <= r_count + 1'b1;
            end

            // Fires during the last allowed cycle so the FSM leaves on that edge
            assign expire = enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wd
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clock, reset, clear, enable};
            assign expire      = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ma_mem_ctrl.sv
// Memory-access stage controller between the EX/MA register and dmem.
// Captures loads/stores, drives dmem commands, stalls the pipeline while
// dmem is busy, and returns load data or ALU pass-through as a one-cycle
// write-back pulse. A watchdog converts a hung dmem into a bus error.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned LH/LHU/SH/LW/SW
// instead of issuing them).
module ma_mem_ctrl
    import ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [ADDR_W-1:0] wb_data,
    output logic              bus_error,
    output logic              misalign_fault,
    output logic [3:0]        mem_read,
    output logic [2:0]        mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [ADDR_W-1:0] mem_writedata,
    input  logic [ADDR_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    ma_state_e         r_state;
    ma_state_e         w_state_next;
    logic              w_stall;

    logic              r_is_load;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wdata;
    logic [4:0]        r_rd;

    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [ADDR_W-1:0] r_wb_data;
    logic              r_bus_error;

    logic              w_mem_req;
    logic              w_alu_req;
    logic              w_misaligned;
    logic              w_in_access;
    logic              w_wd_enable;
    logic              w_expire;

    assign w_mem_req   = req_valid && (req_is_load || req_is_store);
    assign w_alu_req   = req_valid && !req_is_load && !req_is_store;
    assign w_in_access = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_wd_enable = (r_state == ST_WAIT) && mem_busywait;

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misaligned = is_misaligned(req_funct3, req_addr[1:0]);

    // One-cycle fault pulse, visible in RESP alongside the skipped access
    always_ff @(posedge clock) begin
        if (reset)
            r_misalign <= 1'b0;
        else
            r_misalign <= (r_state == ST_IDLE) && w_mem_req && w_misaligned;
    end

    assign misalign_fault = r_misalign;
`else
    assign w_misaligned   = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    ma_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (r_state != ST_WAIT),
        .enable (w_wd_enable),
        .expire (w_expire)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and stall; RESP never accepts, so upstream advances at its end
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_req) begin
                    w_stall      = 1'b1;
                    w_state_next = w_misaligned ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_stall      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (!mem_busywait || w_expire)
                    w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the request; load+store together is treated as a store
    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
        end else if (r_state == ST_IDLE && w_mem_req) begin
            r_is_load  <= req_is_load && !req_is_store;
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
        end
    end

    // Write-back and bus-error pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_bus_error <= 1'b0;
            if (r_state == ST_IDLE && w_alu_req) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= req_addr;
                r_wb_rd    <= req_rd;
            end else if (r_state == ST_WAIT && !mem_busywait) begin
                r_wb_valid <= r_is_load;
                r_wb_data  <= mem_readdata;
                r_wb_rd    <= r_rd;
            end else if (r_state == ST_WAIT && w_expire) begin
                r_wb_valid  <= r_is_load;
                r_wb_data   <= '0;
                r_wb_rd     <= r_rd;
                r_bus_error <= 1'b1;
            end
        end
    end

    assign stall         = w_stall;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign bus_error     = r_bus_error;
    assign mem_read      = (w_in_access && r_is_load)  ? enc_mem_read(r_funct3)  : 4'b0000;
    assign mem_write     = (w_in_access && r_is_store) ? enc_mem_write(r_funct3) : 3'b000;
    assign mem_address   = w_in_access ? r_addr  : '0;
    assign mem_writedata = w_in_access ? r_wdata : '0;

endmodule

// File: tb/tb_ma_mem_ctrl.sv
// Bench for ma_mem_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level reference model. The dmem model
// raises busywait for a chosen number of cycles starting with the first
// cycle a command is visible.
module tb_ma_mem_ctrl;

    localparam int TMO  = 8;
    localparam int MAXC = 40;
`ifdef MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, wb_valid, bus_error, misalign_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_busywait;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          stall_cycles;
        logic [3:0]  rd_c1;
        logic [2:0]  wr_c1;
        logic [31:0] addr_c1;
        logic [31:0] wdata_c1;
        bit          held_ok;
        int          wb_count;
        logic [31:0] wb_data;
        logic [4:0]  wb_rd;
        int          wb_cycle;
        int          be_count;
        int          mf_count;
        bit          any_read;
        bit          hung;
    } obs_t;

    always #5 clock = ~clock;

    ma_mem_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_error(bus_error), .misalign_fault(misalign_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    function automatic obs_t obs_init();
        obs_t o;
        o.stall_cycles = 0; o.rd_c1 = '0; o.wr_c1 = '0; o.addr_c1 = '0; o.wdata_c1 = '0;
        o.held_ok = 1'b1; o.wb_count = 0; o.wb_data = '0; o.wb_rd = '0; o.wb_cycle = -1;
        o.be_count = 0; o.mf_count = 0; o.any_read = 1'b0; o.hung = 1'b0;
        return o;
    endfunction

    // Transaction-level reference: what one request should look like end to end.
    // A mem op spends ISSUE plus W cycles in WAIT; dmem busy for N cycles from
    // ISSUE means W = max(N,1) unless busy is still high on the TMO-th WAIT cycle.
    function automatic obs_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [4:0] rd, input int busy_n,
                                   input logic [31:0] rdata);
        obs_t e;
        bit   mis, to;
        int   w;
        e = obs_init();
        if (!ld && !st) begin
            e.wb_count = 1; e.wb_data = addr; e.wb_rd = rd; e.wb_cycle = 1;
            return e;
        end
        mis = MIS_EN && ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
        if (mis) begin
            e.stall_cycles = 1; e.mf_count = 1;
            return e;
        end
        to = (busy_n > TMO);
        w  = to ? TMO : ((busy_n < 1) ? 1 : busy_n);
        e.stall_cycles = 2 + w;
        e.addr_c1      = addr;
        e.wdata_c1     = wdata;
        e.be_count     = to ? 1 : 0;
        if (st) begin
            e.wr_c1 = {1'b1, f3[1:0]};
        end else begin
            e.rd_c1    = {1'b1, f3};
            e.any_read = 1'b1;
            e.wb_count = 1;
            e.wb_data  = to ? 32'h0 : rdata;
            e.wb_rd    = rd;
            e.wb_cycle = 2 + w;
        end
        return e;
    endfunction

    // Drive one request, play dmem, and record what the DUT did cycle by cycle.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input int busy_n,
                           input logic [31:0] rdata, output obs_t o);
        int done_c;
        bit busy;
        bit finished;
        o = obs_init();
        done_c = -1;
        finished = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        mem_busywait = 1'b0; mem_readdata = $urandom;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clock);
            if (stall) o.stall_cycles++;
            if (c == 1) begin
                o.rd_c1 = mem_read; o.wr_c1 = mem_write;
                o.addr_c1 = mem_address; o.wdata_c1 = mem_writedata;
            end
            if (c > 1 && stall && (mem_read !== o.rd_c1 || mem_write !== o.wr_c1 || mem_address !== o.addr_c1))
                o.held_ok = 1'b0;
            if (mem_read != 4'b0) o.any_read = 1'b1;
            if (wb_valid) begin
                o.wb_count++; o.wb_data = wb_data; o.wb_rd = wb_rd; o.wb_cycle = c;
            end
            if (bus_error) o.be_count++;
            if (misalign_fault) o.mf_count++;
            if (done_c < 0 && !stall) done_c = c;
            if (done_c >= 0 && c == done_c + 1) begin
                finished = 1'b1;
                break;
            end
            @(posedge clock); #1;
            busy = (done_c < 0) && (c + 1 <= busy_n);
            mem_busywait = busy;
            mem_readdata = busy ? $urandom : rdata;
            if (done_c >= 0) begin
                req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
            end
        end
        if (!finished) o.hung = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_busywait = 1'b0; mem_readdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({stall, wb_valid, bus_error, misalign_fault} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000", {stall, wb_valid, bus_error, misalign_fault});
        end
        n_checks++;
        if ({mem_read, mem_write} !== 7'b0) begin
            n_fail++; $display("FAIL reset_mem_cmd: got %h/%h required 0/0", mem_read, mem_write);
        end
        n_checks++;
        if ({mem_address, mem_writedata, wb_data, wb_rd} !== 101'b0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_rd=%0d required all 0",
                               mem_address, mem_writedata, wb_data, wb_rd);
        end
        @(posedge clock); #1 reset = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_store();
        obs_t o;
        run_txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hAABBCCDD, 5'd3, 2, 32'h0, o);
        $display("txn SW addr=00000010 data=aabbccdd stall=%0d", o.stall_cycles);
        n_checks++;
        if (o.wr_c1 !== 3'b110) begin n_fail++; $display("FAIL sw_mem_write: got %b required 110", o.wr_c1); end
        n_checks++;
        if (!o.held_ok) begin n_fail++; $display("FAIL sw_held: command changed during WAIT, required stable"); end
        n_checks++;
        if (o.stall_cycles != 4) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d required 4", o.stall_cycles); end
        n_checks++;
        if (o.wb_count != 0) begin n_fail++; $display("FAIL sw_wb_valid: got %0d pulses required 0", o.wb_count); end
        n_checks++;
        if (o.addr_c1 !== 32'h10 || o.wdata_c1 !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL sw_addr_data: got %h/%h required 00000010/aabbccdd", o.addr_c1, o.wdata_c1);
        end
        n_checks++;
        if (o.any_read || o.hung) begin n_fail++; $display("FAIL sw_no_read: read=%0b hung=%0b required 0/0", o.any_read, o.hung); end
    endtask

    task automatic test_load();
        obs_t o;
        run_txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1, 32'hAABBCCDD, o);
        $display("txn LW addr=00000010 rd=5 wb_data=%h", o.wb_data);
        n_checks++;
        if (o.rd_c1 !== 4'b1010) begin n_fail++; $display("FAIL lw_mem_read: got %b required 1010", o.rd_c1); end
        n_checks++;
        if (o.wb_count != 1) begin n_fail++; $display("FAIL lw_wb_pulses: got %0d required 1", o.wb_count); end
        n_checks++;
        if (o.wb_data !== 32'hAABBCCDD || o.wb_rd !== 5'd5) begin
            n_fail++; $display("FAIL lw_wb: got %h rd=%0d required aabbccdd rd=5", o.wb_data, o.wb_rd);
        end
        n_checks++;
        if (o.wb_cycle != 3) begin n_fail++; $display("FAIL lw_latency: got %0d required 3", o.wb_cycle); end
    endtask

    task automatic test_alu();
        obs_t o;
        run_txn(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd7, 0, 32'h0, o);
        $display("txn ALU data=00001234 rd=7");
        n_checks++;
        if (o.wb_count != 1 || o.wb_cycle != 1) begin
            n_fail++; $display("FAIL alu_wb_timing: pulses=%0d cycle=%0d required 1/1", o.wb_count, o.wb_cycle);
        end
        n_checks++;
        if (o.wb_data !== 32'h1234 || o.wb_rd !== 5'd7) begin
            n_fail++; $display("FAIL alu_wb: got %h rd=%0d required 00001234 rd=7", o.wb_data, o.wb_rd);
        end
        n_checks++;
        if (o.stall_cycles != 0 || o.any_read) begin
            n_fail++; $display("FAIL alu_no_stall: stall=%0d read=%0b required 0/0", o.stall_cycles, o.any_read);
        end
    endtask

    task automatic test_timeout();
        obs_t o, o2;
        run_txn(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 5'd9, 1000, 32'h5555_5555, o);
        $display("txn LB hung dmem bus_error=%0d", o.be_count);
        n_checks++;
        if (o.be_count != 1) begin n_fail++; $display("FAIL tmo_bus_error: got %0d pulses required 1", o.be_count); end
        n_checks++;
        if (o.stall_cycles != 2 + TMO) begin n_fail++; $display("FAIL tmo_stall: got %0d required %0d", o.stall_cycles, 2 + TMO); end
        n_checks++;
        if (o.wb_count != 1 || o.wb_data !== 32'h0 || o.wb_cycle != 2 + TMO) begin
            n_fail++; $display("FAIL tmo_wb: pulses=%0d data=%h cycle=%0d required 1/0/%0d",
                               o.wb_count, o.wb_data, o.wb_cycle, 2 + TMO);
        end
        run_txn(1'b0, 1'b0, 3'b000, 32'hCAFE, 32'h0, 5'd1, 0, 32'h0, o2);
        $display("txn ALU after timeout");
        n_checks++;
        if (o2.wb_cycle != 1 || o2.wb_data !== 32'hCAFE) begin
            n_fail++; $display("FAIL tmo_back_to_idle: cycle=%0d data=%h required 1/0000cafe", o2.wb_cycle, o2.wb_data);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   wb_seen;
        @(posedge clock); #1;
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h40; req_rd = 5'd4; mem_busywait = 1'b0;
        @(posedge clock); #1 mem_busywait = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++;
        if (mem_read !== 4'b1000 || !stall) begin
            n_fail++; $display("FAIL rst_pre_wait: read=%b stall=%b required 1000/1", mem_read, stall);
        end
        @(posedge clock); #1;
        reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0;
        @(posedge clock); #1;
        wb_seen = 0;
        @(negedge clock);
        n_checks++;
        if (mem_read !== 4'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: read=%b stall=%b required 0000/0", mem_read, stall);
        end
        if (wb_valid) wb_seen++;
        @(posedge clock); #1 reset = 1'b0; mem_busywait = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (wb_valid) wb_seen++;
        end
        n_checks++;
        if (wb_seen != 0) begin n_fail++; $display("FAIL rst_mid_no_wb: got %0d pulses required 0", wb_seen); end
        run_txn(1'b1, 1'b0, 3'b101, 32'h30, 32'h0, 5'd6, 1, 32'h0000_BEEF, o);
        $display("txn LHU addr=00000030 after reset wb_data=%h", o.wb_data);
        n_checks++;
        if (o.rd_c1 !== 4'b1101 || o.wb_count != 1 || o.wb_data !== 32'h0000_BEEF || o.wb_rd !== 5'd6) begin
            n_fail++; $display("FAIL rst_then_lhu: read=%b pulses=%0d data=%h rd=%0d required 1101/1/0000beef/6",
                               o.rd_c1, o.wb_count, o.wb_data, o.wb_rd);
        end
    endtask

    task automatic test_misalign();
        obs_t o, e;
        run_txn(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 5'd2, 1, 32'h1111_2222, o);
        e = model(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 5'd2, 1, 32'h1111_2222);
        $display("txn LW addr=00000012 fault=%0d", o.mf_count);
        n_checks++;
        if (o.mf_count != e.mf_count) begin n_fail++; $display("FAIL mis_fault: got %0d required %0d", o.mf_count, e.mf_count); end
        n_checks++;
        if (o.rd_c1 !== e.rd_c1 || o.any_read != e.any_read) begin
            n_fail++; $display("FAIL mis_mem_read: got %b required %b", o.rd_c1, e.rd_c1);
        end
        n_checks++;
        if (o.addr_c1 !== e.addr_c1 || o.wb_count != e.wb_count) begin
            n_fail++; $display("FAIL mis_addr_wb: addr=%h pulses=%0d required %h/%0d",
                               o.addr_c1, o.wb_count, e.addr_c1, e.wb_count);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr, wdata, rdata;
        logic [4:0] rd;
        int kind, busy_n;
        logic [2:0] load_f3 [5];
        load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
        load_f3[3] = 3'b100; load_f3[4] = 3'b101;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            ld = (kind == 1) || (kind == 3);
            st = (kind == 2) || (kind == 3);
            f3 = st ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            addr = $urandom; wdata = $urandom; rdata = $urandom; rd = 5'($urandom);
            busy_n = $urandom_range(0, 11);
            run_txn(ld, st, f3, addr, wdata, rd, busy_n, rdata, o);
            e = model(ld, st, f3, addr, wdata, rd, busy_n, rdata);
            $display("txn rnd%0d ld=%0b st=%0b f3=%0d addr=%h busy=%0d", i, ld, st, f3, addr, busy_n);
            n_checks++;
            if (o.hung || o.stall_cycles != e.stall_cycles || !o.held_ok) begin
                n_fail++; $display("FAIL rnd%0d_stall: got %0d held=%0b hung=%0b required %0d",
                                   i, o.stall_cycles, o.held_ok, o.hung, e.stall_cycles);
            end
            n_checks++;
            if (o.rd_c1 !== e.rd_c1 || o.wr_c1 !== e.wr_c1 || o.addr_c1 !== e.addr_c1) begin
                n_fail++; $display("FAIL rnd%0d_cmd: got %b/%b/%h required %b/%b/%h",
                                   i, o.rd_c1, o.wr_c1, o.addr_c1, e.rd_c1, e.wr_c1, e.addr_c1);
            end
            if (st && e.stall_cycles > 1) begin
                n_checks++;
                if (o.wdata_c1 !== e.wdata_c1) begin
                    n_fail++; $display("FAIL rnd%0d_wdata: got %h required %h", i, o.wdata_c1, e.wdata_c1);
                end
            end
            n_checks++;
            if (o.wb_count != e.wb_count || o.be_count != e.be_count || o.mf_count != e.mf_count) begin
                n_fail++; $display("FAIL rnd%0d_pulses: wb=%0d be=%0d mf=%0d required %0d/%0d/%0d",
                                   i, o.wb_count, o.be_count, o.mf_count, e.wb_count, e.be_count, e.mf_count);
            end
            if (e.wb_count == 1) begin
                n_checks++;
                if (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd || o.wb_cycle != e.wb_cycle) begin
                    n_fail++; $display("FAIL rnd%0d_wb: got %h rd=%0d cyc=%0d required %h rd=%0d cyc=%0d",
                                       i, o.wb_data, o.wb_rd, o.wb_cycle, e.wb_data, e.wb_rd, e.wb_cycle);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_alu();
        test_timeout();
        test_reset_mid();
        test_misalign();
        test_random();
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
